// File: rtl/send_ack_arbiter_pkg.sv
// Shared types and helpers for the send/ack port arbiter.
// Holds the FSM state encoding and the round-robin pick function.
package send_ack_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_REL  = 2'd2,
        WAIT_PLOW = 2'd3
    } state_t;

    localparam int DATA_W_DEF = 4;
    localparam int MAX_REQ    = 8;

    // Returns {valid, index} of the first set bit of req[n-1:0] strictly after
    // last_idx, wrapping. Iterating from the far end lets the nearest hit win.
    function automatic logic [3:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last_idx,
        input int                 n
    );
        logic [3:0] res;
        int         cand;
        res = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            if (i <= n) begin
                cand = (int'(last_idx) + i) % n;
                if (req[cand[2:0]]) res = {1'b1, cand[2:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/send_ack_arbiter_rr_picker.sv
// Combinational rotate-priority encoder: picks the next requester after
// last_grant, wrapping modulo NUM_REQ.
module rr_picker
    import send_ack_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic               valid,
    output logic [IDW-1:0]     idx
);

    logic [MAX_REQ-1:0] req_ext;
    logic [2:0]         last_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        last_ext             = 3'(last_grant);
        pick                 = rr_pick(req_ext, last_ext, NUM_REQ);
    end

    assign valid = pick[3];
    assign idx   = IDW'(pick[2:0]);

endmodule

// File: rtl/send_ack_arbiter.sv
// Shares one four-phase send/ack peripheral port among NUM_REQ requesters,
// round-robin, with a watchdog that aborts unacknowledged sends.
module send_ack_arbiter
    import send_ack_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 16,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      arb_clk,
    input  logic                      arb_rst,
    input  logic [NUM_REQ-1:0]        req_send,
    input  logic [NUM_REQ*DATA_W-1:0] req_dados,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      per_send,
    output logic [DATA_W-1:0]         per_dados,
    input  logic                      per_ack,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [IDW-1:0]            timeout_id
);

    localparam int              WDW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WD_LAST  = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [IDW-1:0]  LAST_RST = IDW'(NUM_REQ - 1);

    state_t              state, nxt_state;
    logic [WDW-1:0]      wdog, nxt_wdog;
    logic [NUM_REQ-1:0]  nxt_req_ack;
    logic                nxt_per_send;
    logic [DATA_W-1:0]   nxt_per_dados;
    logic [IDW-1:0]      nxt_grant_id;
    logic                nxt_timeout_err;
    logic [IDW-1:0]      nxt_timeout_id;

    logic                pick_valid;
    logic [IDW-1:0]      pick_idx;
    logic                gnt_send;
    logic [DATA_W-1:0]   dados_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign dados_arr[i] = req_dados[i*DATA_W +: DATA_W];
    end

    rr_picker #(
        .NUM_REQ    (NUM_REQ),
        .IDW        (IDW)
    ) u_picker (
        .req        (req_send),
        .last_grant (grant_id),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign gnt_send = req_send[grant_id];

    always_comb begin
        nxt_state       = state;
        nxt_wdog        = wdog;
        nxt_req_ack     = req_ack;
        nxt_per_send    = per_send;
        nxt_per_dados   = per_dados;
        nxt_grant_id    = grant_id;
        nxt_timeout_err = 1'b0;
        nxt_timeout_id  = timeout_id;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    nxt_grant_id  = pick_idx;
                    nxt_per_dados = dados_arr[pick_idx];
                    nxt_per_send  = 1'b1;
                    nxt_wdog      = '0;
                    nxt_state     = SEND;
                end
            end
            SEND: begin
                // Ack beats both a requester abort and an expiring watchdog.
                if (per_ack) begin
                    nxt_req_ack = NUM_REQ'(1) << grant_id;
                    nxt_state   = WAIT_REL;
                end else if (!gnt_send) begin
                    nxt_per_send = 1'b0;
                    nxt_state    = WAIT_PLOW;
                end else if (TIMEOUT != 0 && wdog == WD_LAST) begin
                    nxt_per_send    = 1'b0;
                    nxt_timeout_err = 1'b1;
                    nxt_timeout_id  = grant_id;
                    nxt_state       = WAIT_PLOW;
                end else if (wdog != '1) begin
                    nxt_wdog = wdog + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!gnt_send) begin
                    nxt_req_ack  = '0;
                    nxt_per_send = 1'b0;
                    nxt_state    = WAIT_PLOW;
                end
            end
            WAIT_PLOW: begin
                // Exit only; the next grant is made from IDLE one edge later.
                if (!per_ack) nxt_state = IDLE;
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            state       <= IDLE;
            wdog        <= '0;
            req_ack     <= '0;
            per_send    <= 1'b0;
            per_dados   <= '0;
            grant_id    <= LAST_RST;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            timeout_id  <= '0;
        end else begin
            state       <= nxt_state;
            wdog        <= nxt_wdog;
            req_ack     <= nxt_req_ack;
            per_send    <= nxt_per_send;
            per_dados   <= nxt_per_dados;
            grant_id    <= nxt_grant_id;
            busy        <= (nxt_state != IDLE);
            timeout_err <= nxt_timeout_err;
            timeout_id  <= nxt_timeout_id;
        end
    end

endmodule

// File: tb/tb_send_ack_arbiter.sv
// Bench for send_ack_arbiter: directed scenarios plus random requester and
// peripheral agents, all checked each cycle against a transaction-level model.
module tb_send_ack_arbiter;

    localparam int N   = 4;
    localparam int DW  = 4;
    localparam int TO  = 16;
    localparam int IDW = 2;

    logic            arb_clk   = 1'b0;
    logic            arb_rst   = 1'b1;
    logic [N-1:0]    req_send  = '0;
    logic [N*DW-1:0] req_dados = '0;
    logic            per_ack   = 1'b0;
    logic [N-1:0]    req_ack;
    logic            per_send;
    logic [DW-1:0]   per_dados;
    logic [IDW-1:0]  grant_id;
    logic            busy;
    logic            timeout_err;
    logic [IDW-1:0]  timeout_id;

    int vectors     = 0;
    int miscompares = 0;

    send_ack_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT(TO), .IDW(IDW)) dut (
        .arb_clk     (arb_clk),
        .arb_rst     (arb_rst),
        .req_send    (req_send),
        .req_dados   (req_dados),
        .req_ack     (req_ack),
        .per_send    (per_send),
        .per_dados   (per_dados),
        .per_ack     (per_ack),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err),
        .timeout_id  (timeout_id)
    );

    always #5 arb_clk = ~arb_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked by its progress
    // (granted, acknowledged, closing) and its age in cycles since the send.
    logic          m_busy, m_acked, m_closing, m_send, m_terr;
    int            m_gid, m_tid, m_age;
    logic [DW-1:0] m_data;

    function automatic int next_grant(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(posedge arb_clk or posedge arb_rst) begin
        if (arb_rst) begin
            m_busy <= 1'b0; m_acked <= 1'b0; m_closing <= 1'b0; m_send <= 1'b0;
            m_terr <= 1'b0; m_gid <= N - 1; m_tid <= 0; m_age <= 0; m_data <= '0;
        end else begin
            m_terr <= 1'b0;
            if (!m_busy) begin
                if (req_send != '0) begin
                    m_gid     <= next_grant(req_send, m_gid);
                    m_data    <= req_dados[next_grant(req_send, m_gid)*DW +: DW];
                    m_send    <= 1'b1;
                    m_age     <= 0;
                    m_busy    <= 1'b1;
                    m_acked   <= 1'b0;
                    m_closing <= 1'b0;
                end
            end else if (m_closing) begin
                if (!per_ack) begin m_busy <= 1'b0; m_closing <= 1'b0; end
            end else if (m_acked) begin
                if (!req_send[m_gid]) begin m_acked <= 1'b0; m_send <= 1'b0; m_closing <= 1'b1; end
            end else if (per_ack) begin
                m_acked <= 1'b1;
            end else if (!req_send[m_gid]) begin
                m_send <= 1'b0; m_closing <= 1'b1;
            end else if (TO != 0 && m_age == TO - 1) begin
                m_send <= 1'b0; m_closing <= 1'b1; m_terr <= 1'b1; m_tid <= m_gid;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    // Agent knobs
    bit auto_req = 0, auto_per = 0, rnd_data = 1;
    int raise_pct = 0, drop_pct = 0, abort_pct = 0, per_fixed = -1;
    bit p_armed = 0;
    int p_cnt = 0;
    int dly [9] = '{0, 1, 2, 3, 5, 14, 15, 16, 40};

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            if (!req_send[i]) begin
                if (rnd_data) req_dados[i*DW +: DW] = DW'($urandom);
                if (!req_ack[i] && $urandom_range(0, 99) < raise_pct) req_send[i] = 1'b1;
            end else if (req_ack[i]) begin
                if ($urandom_range(0, 99) < drop_pct) req_send[i] = 1'b0;
            end else if ($urandom_range(0, 99) < abort_pct) begin
                req_send[i] = 1'b0;
            end
        end
    endtask

    task automatic drive_per();
        if (per_send && !per_ack) begin
            if (!p_armed) begin
                p_armed = 1;
                p_cnt   = (per_fixed >= 0) ? per_fixed : dly[$urandom_range(0, 8)];
            end
            if (p_cnt == 0) per_ack = 1'b1;
            else p_cnt--;
        end else if (!per_send) begin
            p_armed = 0;
            if (per_ack && $urandom_range(0, 1) == 1) per_ack = 1'b0;
        end
    endtask

    task automatic step();
        logic [N-1:0] exp_ack;
        @(negedge arb_clk);
        exp_ack = '0;
        if (m_acked) exp_ack[m_gid] = 1'b1;
        chk("per_send",    32'(per_send),    32'(m_send));
        chk("req_ack",     32'(req_ack),     32'(exp_ack));
        chk("per_dados",   32'(per_dados),   32'(m_data));
        chk("grant_id",    32'(grant_id),    32'(m_gid));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("timeout_id",  32'(timeout_id),  32'(m_tid));
        if (auto_req) drive_reqs();
        if (auto_per) drive_per();
    endtask

    task automatic wait_send(input string tag);
        int g = 0;
        while (per_send !== 1'b1 && g < 60) begin step(); g++; end
        chk(tag, 32'(per_send), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int g = 0;
        while (busy !== 1'b0 && g < 100) begin step(); g++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        arb_rst  = 1'b1;
        req_send = '0;
        per_ack  = 1'b0;
        repeat (2) step();
        arb_rst  = 1'b0;
    endtask

    initial begin
        int hi, g, pulses;

        // Reset state
        repeat (2) step();
        chk("rst_grant_id", 32'(grant_id), 32'(N - 1));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_per_send", 32'(per_send), 32'd0);
        arb_rst = 1'b0;
        step();

        // Single request, peripheral acks after 3 cycles
        req_dados[2*DW +: DW] = 4'hA;
        req_send = 4'b0100;
        wait_send("t1_send");
        chk("t1_dados", 32'(per_dados), 32'hA);
        chk("t1_gid", 32'(grant_id), 32'd2);
        repeat (3) step();
        per_ack = 1'b1;
        step();
        chk("t1_ack", 32'(req_ack), 32'b0100);
        req_send = '0;
        step();
        chk("t1_send_low", 32'(per_send), 32'd0);
        chk("t1_busy_hold", 32'(busy), 32'd1);
        per_ack = 1'b0;
        step();
        chk("t1_idle", 32'(busy), 32'd0);

        // Round-robin with all requesters pending from reset
        do_reset();
        req_dados = 16'h4321;
        rnd_data = 0; raise_pct = 100; drop_pct = 100; abort_pct = 0; per_fixed = 1;
        auto_req = 1; auto_per = 1;
        req_send = '1;
        for (int t = 0; t < 5; t++) begin
            wait_send("t2_send");
            chk("t2_gid", 32'(grant_id), 32'(t % N));
            chk("t2_dados", 32'(per_dados), 32'((t % N) + 1));
            g = 0;
            while (per_send === 1'b1 && g < 60) begin step(); g++; end
        end
        auto_req = 0;
        req_send = '0;
        wait_idle("t2_idle");
        auto_per = 0;
        per_ack = 1'b0;

        // Watchdog: no ack at all
        req_send = 4'b0010;
        wait_send("t3_send");
        hi = 0; g = 0;
        while (per_send === 1'b1 && g < 60) begin hi++; g++; step(); end
        chk("t3_send_cycles", 32'(hi), 32'd16);
        req_send = '0;
        chk("t3_tid", 32'(timeout_id), 32'd1);
        pulses = 0;
        repeat (4) begin
            if (timeout_err === 1'b1) pulses++;
            step();
        end
        chk("t3_pulses", 32'(pulses), 32'd1);
        chk("t3_no_ack", 32'(req_ack), 32'd0);
        wait_idle("t3_idle");

        // Requester abort two cycles into SEND, late peripheral ack
        req_send = 4'b1000;
        wait_send("t4_send");
        repeat (2) step();
        req_send = '0;
        step();
        chk("t4_send_low", 32'(per_send), 32'd0);
        per_ack = 1'b1;
        repeat (3) begin
            step();
            chk("t4_busy_wait", 32'(busy), 32'd1);
            chk("t4_no_ack", 32'(req_ack), 32'd0);
        end
        per_ack = 1'b0;
        step();
        chk("t4_idle", 32'(busy), 32'd0);

        // Reset during WAIT_REL
        req_send = 4'b0100;
        wait_send("t5_send");
        per_ack = 1'b1;
        step();
        chk("t5_ack", 32'(req_ack), 32'b0100);
        #2 arb_rst = 1'b1;
        #1;
        chk("t5_rst_ack", 32'(req_ack), 32'd0);
        chk("t5_rst_send", 32'(per_send), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        per_ack = 1'b0;
        req_send = 4'b0101;
        step();
        arb_rst = 1'b0;
        step();
        chk("t5_first_gid", 32'(grant_id), 32'd0);
        chk("t5_first_dados", 32'(per_dados), 32'h1);
        req_send = '0;
        wait_idle("t5_idle");

        // Ack arrives on the very cycle the watchdog would expire
        req_send = 4'b0010;
        wait_send("t6_send");
        repeat (15) step();
        per_ack = 1'b1;
        step();
        chk("t6_ack", 32'(req_ack), 32'b0010);
        chk("t6_no_terr", 32'(timeout_err), 32'd0);
        req_send = '0;
        step();
        per_ack = 1'b0;
        wait_idle("t6_idle");

        // Random traffic
        do_reset();
        rnd_data = 1; raise_pct = 30; drop_pct = 40; abort_pct = 3; per_fixed = -1;
        auto_req = 1; auto_per = 1;
        repeat (3000) step();
        raise_pct = 0; abort_pct = 100; drop_pct = 100;
        g = 0;
        while ((busy !== 1'b0 || req_send != '0) && g < 300) begin step(); g++; end
        chk("rand_quiesce", 32'(busy), 32'd0);
        auto_req = 0; auto_per = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
